// File: rtl/isa_pkg.sv
// Shared ISA constants for the instruction encoder and the core decoder.
// Opcode fields and immediate bounds live here so encode/decode never drift.
package isa_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_ORI = 3'd1,
        OP_LD  = 3'd2,
        OP_ST  = 3'd3,
        OP_BNE = 3'd4
    } op_e;

    localparam logic [16:0] OPC_ADD = 17'b00000000000100000;
    localparam logic [9:0]  OPC_ORI = 10'b0000001110;
    localparam logic [9:0]  OPC_LD  = 10'b0010101000;
    localparam logic [9:0]  OPC_ST  = 10'b0010100100;
    localparam logic [5:0]  OPC_BNE = 6'b010111;

    localparam int IMM_ORI_MIN = 0;
    localparam int IMM_ORI_MAX = 4095;
    localparam int IMM_MEM_MIN = -2048;
    localparam int IMM_MEM_MAX = 2047;
    localparam int IMM_BNE_MIN = -32768;
    localparam int IMM_BNE_MAX = 32767;

    // True when the immediate, read as signed, lies in [lo, hi].
    function automatic logic imm_in_range(
        input logic [31:0] imm,
        input int          lo,
        input int          hi
    );
        return ($signed(imm) >= lo) && ($signed(imm) <= hi);
    endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Micro-op input stream and instruction memory write port.
// master = loader side, slave = encoder side.
interface inst_encoder_if;

    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [4:0]  in_rd;
    logic [4:0]  in_rj;
    logic [4:0]  in_rk;
    logic [31:0] in_imm;

    logic        mem_we;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;

    modport master (
        output in_valid, in_op, in_rd, in_rj, in_rk, in_imm,
        output mem_ready,
        input  in_ready,
        input  mem_we, mem_addr, mem_data
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rj, in_rk, in_imm,
        input  mem_ready,
        output in_ready,
        output mem_we, mem_addr, mem_data
    );

endinterface

// File: rtl/inst_pack.sv
// Combinational micro-op packer: fields in, 32-bit word and legal flag out.
// Illegal ops and out-of-range immediates clear legal_o.
module inst_pack
    import isa_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rj_i,
    input  logic [4:0]  rk_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o,
    output logic        legal_o
);

    // Select the format for the op and range-check its immediate.
    always_comb begin
        word_o  = '0;
        legal_o = 1'b0;
        case (op_i)
            OP_ADD: begin
                word_o  = {OPC_ADD, rk_i, rj_i, rd_i};
                legal_o = 1'b1;
            end
            OP_ORI: begin
                word_o  = {OPC_ORI, imm_i[11:0], rj_i, rd_i};
                legal_o = imm_in_range(imm_i, IMM_ORI_MIN, IMM_ORI_MAX);
            end
            OP_LD: begin
                word_o  = {OPC_LD, imm_i[11:0], rj_i, rd_i};
                legal_o = imm_in_range(imm_i, IMM_MEM_MIN, IMM_MEM_MAX);
            end
            OP_ST: begin
                word_o  = {OPC_ST, imm_i[11:0], rj_i, rd_i};
                legal_o = imm_in_range(imm_i, IMM_MEM_MIN, IMM_MEM_MAX);
            end
            OP_BNE: begin
                word_o  = {OPC_BNE, imm_i[15:0], rj_i, rd_i};
                legal_o = imm_in_range(imm_i, IMM_BNE_MIN, IMM_BNE_MAX);
            end
            default: begin
                word_o  = '0;
                legal_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Streaming instruction encoder: packs accepted micro-ops and writes them
// to sequential instruction memory addresses through one output register.
module inst_encoder
    import isa_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] ADDR_STEP = 32'd4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    inst_encoder_if.slave  bus,
    output logic [15:0]    word_cnt,
    output logic           err,
    output logic [7:0]     err_cnt
);

    logic [31:0] word;
    logic        legal;

    logic        mem_we_q,   mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_data_q, mem_data_d;
    logic [31:0] ptr_q,      ptr_d;
    logic        stale_q,    stale_d;
    logic [15:0] wcnt_q,     wcnt_d;
    logic        err_q,      err_d;
    logic [7:0]  ecnt_q,     ecnt_d;

    logic in_ready;
    logic acc;
    logic take;
    logic rej;
    logic drain;

    inst_pack u_pack (
        .op_i    (bus.in_op),
        .rd_i    (bus.in_rd),
        .rj_i    (bus.in_rj),
        .rk_i    (bus.in_rk),
        .imm_i   (bus.in_imm),
        .word_o  (word),
        .legal_o (legal)
    );

    assign in_ready = (!mem_we_q || bus.mem_ready) && !start;
    assign acc      = bus.in_valid && in_ready;
    assign take     = acc && legal;
    assign rej      = acc && !legal;
    assign drain    = mem_we_q && bus.mem_ready;

    // Next state: load/drain the output slot, advance pointer, count.
    // A word left pending across start is marked stale so it is not counted.
    always_comb begin
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        ptr_d      = ptr_q;
        stale_d    = stale_q;
        wcnt_d     = wcnt_q;
        err_d      = err_q;
        ecnt_d     = ecnt_q;

        if (take) begin
            mem_we_d   = 1'b1;
            mem_addr_d = ptr_q;
            mem_data_d = word;
            ptr_d      = ptr_q + ADDR_STEP;
            stale_d    = 1'b0;
        end else if (drain) begin
            mem_we_d = 1'b0;
            stale_d  = 1'b0;
        end

        if (drain && !stale_q && wcnt_q != 16'hFFFF) begin
            wcnt_d = wcnt_q + 16'd1;
        end

        if (rej) begin
            err_d = 1'b1;
            if (ecnt_q != 8'hFF) begin
                ecnt_d = ecnt_q + 8'd1;
            end
        end

        if (start) begin
            ptr_d   = BASE_ADDR;
            stale_d = mem_we_q && !bus.mem_ready;
            wcnt_d  = '0;
            err_d   = 1'b0;
            ecnt_d  = '0;
        end
    end

    // State registers with synchronous reset; reset drops any pending word.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we_q   <= 1'b0;
            mem_addr_q <= BASE_ADDR;
            mem_data_q <= '0;
            ptr_q      <= BASE_ADDR;
            stale_q    <= 1'b0;
            wcnt_q     <= '0;
            err_q      <= 1'b0;
            ecnt_q     <= '0;
        end else begin
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            ptr_q      <= ptr_d;
            stale_q    <= stale_d;
            wcnt_q     <= wcnt_d;
            err_q      <= err_d;
            ecnt_q     <= ecnt_d;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_data = mem_data_q;
    assign word_cnt     = wcnt_q;
    assign err          = err_q;
    assign err_cnt      = ecnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: scoreboard of expected writes, checked on drain.
// Drives at posedge+1, samples at negedge.
module tb_inst_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] word_cnt;
    logic        err;
    logic [7:0]  err_cnt;

    inst_encoder_if bus ();

    inst_encoder #(
        .BASE_ADDR (32'h0000_0000),
        .ADDR_STEP (32'd4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus),
        .word_cnt (word_cnt),
        .err      (err),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        stale;
    } sb_t;

    sb_t         sbq[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_ptr = 32'h0;
    int          exp_wcnt = 0;
    int          exp_ecnt = 0;
    logic        exp_err = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference encoder, written from the instruction formats.
    function automatic logic [32:0] model(
        input logic [2:0] op,
        input logic [4:0] rd,
        input logic [4:0] rj,
        input logic [4:0] rk,
        input int         imm
    );
        logic [31:0] w;
        logic [31:0] u;
        logic [31:0] regs;
        logic        ok;
        u    = imm;
        regs = ({27'd0, rj} << 5) | {27'd0, rd};
        case (op)
            3'd0: begin
                ok = 1'b1;
                w  = 32'h0010_0000 | ({27'd0, rk} << 10) | regs;
            end
            3'd1: begin
                ok = (imm >= 0) && (imm <= 4095);
                w  = 32'h0380_0000 | ((u & 32'hFFF) << 10) | regs;
            end
            3'd2: begin
                ok = (imm >= -2048) && (imm <= 2047);
                w  = 32'h2A00_0000 | ((u & 32'hFFF) << 10) | regs;
            end
            3'd3: begin
                ok = (imm >= -2048) && (imm <= 2047);
                w  = 32'h2900_0000 | ((u & 32'hFFF) << 10) | regs;
            end
            3'd4: begin
                ok = (imm >= -32768) && (imm <= 32767);
                w  = 32'h5C00_0000 | ((u & 32'hFFFF) << 10) | regs;
            end
            default: begin
                ok = 1'b0;
                w  = 32'h0;
            end
        endcase
        return {ok, w};
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Present one micro-op (caller is at posedge+1), wait for handshake.
    task automatic send(
        input logic [2:0] op,
        input logic [4:0] rd,
        input logic [4:0] rj,
        input logic [4:0] rk,
        input int         imm
    );
        logic [32:0] m;
        bit          ok;
        ok           = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_rd    = rd;
        bus.in_rj    = rj;
        bus.in_rk    = rk;
        bus.in_imm   = imm;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("accept_timeout", {31'd0, ok}, 32'd1);
        if (ok) begin
            m = model(op, rd, rj, rk, imm);
            if (m[32]) begin
                sbq.push_back({exp_ptr, m[31:0], 1'b0});
                exp_ptr = exp_ptr + 32'd4;
            end else begin
                exp_err = 1'b1;
                if (exp_ecnt < 255) exp_ecnt++;
            end
        end
        sync();
        bus.in_valid = 1'b0;
    endtask

    // Pulse start for one cycle; in_ready must be low during it.
    task automatic do_start();
        start = 1'b1;
        for (int i = 0; i < sbq.size(); i++) sbq[i].stale = 1'b1;
        exp_ptr  = 32'h0;
        exp_wcnt = 0;
        exp_err  = 1'b0;
        exp_ecnt = 0;
        @(negedge clk);
        chk("start_in_ready", {31'd0, bus.in_ready}, 32'd0);
        sync();
        start = 1'b0;
    endtask

    // Wait until the output slot is empty, bounded.
    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.mem_we) break;
        end
        chk("idle_timeout", {31'd0, bus.mem_we}, 32'd0);
    endtask

    // Output monitor: scoreboard on drain, hold and back-pressure checks.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr  = 32'h0;
    logic [31:0] prev_data  = 32'h0;

    always @(negedge clk) begin
        sb_t e;
        if (!rst) begin
            if (prev_stall) begin
                chk("hold_we", {31'd0, bus.mem_we}, 32'd1);
                chk("hold_addr", bus.mem_addr, prev_addr);
                chk("hold_data", bus.mem_data, prev_data);
            end
            if (bus.mem_we && !bus.mem_ready) begin
                chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
            end
            if (bus.mem_we && bus.mem_ready) begin
                chk("sb_nonempty", {31'd0, sbq.size() != 0}, 32'd1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    chk("wr_addr", bus.mem_addr, e.addr);
                    chk("wr_data", bus.mem_data, e.data);
                    if (!e.stale && exp_wcnt < 65535) exp_wcnt++;
                end
            end
            prev_stall = bus.mem_we && !bus.mem_ready;
            prev_addr  = bus.mem_addr;
            prev_data  = bus.mem_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_op     = 3'd0;
        bus.in_rd     = 5'd0;
        bus.in_rj     = 5'd0;
        bus.in_rk     = 5'd0;
        bus.in_imm    = 32'd0;
        bus.mem_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_we", {31'd0, bus.mem_we}, 32'd0);
        chk("rst_addr", bus.mem_addr, 32'h0);
        chk("rst_data", bus.mem_data, 32'h0);
        chk("rst_wcnt", {16'd0, word_cnt}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_ecnt", {24'd0, err_cnt}, 32'd0);
        sync();
        rst = 1'b0;
        bus.mem_ready = 1'b1;

        send(3'd0, 5'd3, 5'd1, 5'd2, 0);
        @(negedge clk);
        chk("add_data", bus.mem_data, 32'h0010_0823);
        chk("add_addr", bus.mem_addr, 32'h0);
        wait_idle();
        chk("add_wcnt", {16'd0, word_cnt}, 32'd1);
        sync();

        send(3'd1, 5'd5, 5'd0, 5'd0, 4095);
        @(negedge clk);
        chk("ori_data", bus.mem_data, 32'h03BF_FC05);
        chk("ori_addr", bus.mem_addr, 32'h4);
        sync();
        send(3'd1, 5'd5, 5'd0, 5'd0, 4096);
        @(negedge clk);
        chk("ori_rej_err", {31'd0, err}, 32'd1);
        chk("ori_rej_ecnt", {24'd0, err_cnt}, 32'd1);
        chk("ori_rej_we", {31'd0, bus.mem_we}, 32'd0);
        sync();
        send(3'd0, 5'd6, 5'd7, 5'd8, 0);
        @(negedge clk);
        chk("after_rej_addr", bus.mem_addr, 32'h8);
        sync();

        send(3'd4, 5'd1, 5'd2, 5'd0, -4);
        @(negedge clk);
        chk("bne_data", bus.mem_data, 32'h5FFF_F041);
        chk("bne_addr", bus.mem_addr, 32'hC);
        sync();
        send(3'd2, 5'd4, 5'd2, 5'd0, -2048);
        @(negedge clk);
        chk("ld_data", bus.mem_data, 32'h2A20_0044);
        chk("ld_addr", bus.mem_addr, 32'h10);
        sync();

        send(3'd3, 5'd9, 5'd10, 5'd0, 2047);
        send(3'd3, 5'd1, 5'd1, 5'd0, -2049);
        send(3'd2, 5'd2, 5'd3, 5'd0, 2048);
        send(3'd4, 5'd31, 5'd30, 5'd0, 32767);
        send(3'd4, 5'd17, 5'd18, 5'd0, -32768);
        send(3'd4, 5'd1, 5'd1, 5'd0, 32768);
        send(3'd1, 5'd1, 5'd1, 5'd0, -1);
        send(3'd0, 5'd11, 5'd12, 5'd13, 123456);
        send(3'd5, 5'd1, 5'd1, 5'd1, 0);
        wait_idle();
        chk("mix_wcnt", {16'd0, word_cnt}, 32'd9);
        chk("mix_wcnt_sb", {16'd0, word_cnt}, exp_wcnt);
        chk("mix_ecnt", {24'd0, err_cnt}, 32'd6);
        chk("mix_ecnt_sb", {24'd0, err_cnt}, exp_ecnt);
        sync();

        do_start();
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(3'd0, 5'(i), 5'(i + 1), 5'(i + 2), 0);
                end
            end
            begin
                repeat (3) sync();
                bus.mem_ready = 1'b0;
                repeat (3) sync();
                bus.mem_ready = 1'b1;
            end
        join
        wait_idle();
        chk("stream_wcnt", {16'd0, word_cnt}, 32'd8);
        chk("stream_sb", sbq.size(), 32'd0);
        sync();

        send(3'd6, 5'd0, 5'd0, 5'd0, 0);
        bus.mem_ready = 1'b0;
        send(3'd0, 5'd1, 5'd1, 5'd1, 0);
        do_start();
        @(negedge clk);
        chk("start_err", {31'd0, err}, 32'd0);
        chk("start_ecnt", {24'd0, err_cnt}, 32'd0);
        chk("start_wcnt", {16'd0, word_cnt}, 32'd0);
        chk("start_pend_we", {31'd0, bus.mem_we}, 32'd1);
        chk("start_pend_addr", bus.mem_addr, 32'h20);
        sync();
        bus.mem_ready = 1'b1;
        send(3'd0, 5'd2, 5'd3, 5'd4, 0);
        wait_idle();
        chk("start_wcnt1", {16'd0, word_cnt}, 32'd1);
        sync();

        bus.mem_ready = 1'b0;
        send(3'd0, 5'd5, 5'd5, 5'd5, 0);
        rst = 1'b1;
        sbq.delete();
        exp_ptr  = 32'h0;
        exp_wcnt = 0;
        exp_err  = 1'b0;
        exp_ecnt = 0;
        sync();
        @(negedge clk);
        chk("mid_rst_we", {31'd0, bus.mem_we}, 32'd0);
        chk("mid_rst_addr", bus.mem_addr, 32'h0);
        chk("mid_rst_wcnt", {16'd0, word_cnt}, 32'd0);
        chk("mid_rst_ecnt", {24'd0, err_cnt}, 32'd0);
        sync();
        rst = 1'b0;
        bus.mem_ready = 1'b1;
        send(3'd7, 5'd1, 5'd2, 5'd3, 0);
        @(negedge clk);
        chk("op7_err", {31'd0, err}, 32'd1);
        chk("op7_ecnt", {24'd0, err_cnt}, 32'd1);
        chk("op7_we", {31'd0, bus.mem_we}, 32'd0);
        sync();

        repeat (258) send(3'd5, 5'd0, 5'd0, 5'd0, 0);
        @(negedge clk);
        chk("ecnt_sat", {24'd0, err_cnt}, 32'hFF);
        chk("ecnt_sat_sb", {24'd0, err_cnt}, exp_ecnt);
        sync();

        send(3'd3, 5'd7, 5'd8, 5'd0, -1);
        wait_idle();
        chk("final_wcnt", {16'd0, word_cnt}, exp_wcnt);
        chk("final_err", {31'd0, err}, {31'd0, exp_err});
        chk("final_sb", sbq.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
